// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive controller: FSM state encodings and
// oversampling parameters.
package uart_rx_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned OS_MID  = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line. It resets to the
// idle level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff_q <= '1;
    else        ff_q <= {ff_q[0], d};
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 16x-oversampled start/data/stop sequencing with a one-entry
// valid/ready holding register and single-cycle framing/overrun pulses.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            rx_busy,
  output logic            frame_err,
  output logic            overrun
);

  localparam int unsigned BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [4:0]    MID_TICK = 5'(OS_MID);
  localparam logic [4:0]    OS_LAST  = 5'(OS_RATE - 1);
  localparam logic [4:0]    SB_LAST  = 5'(SB_TICK - 1);

  logic            rx_s;
  logic [1:0]      state_q, state_d;
  logic [4:0]      tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            armed_q, armed_d;
  logic [1:0]      fill_q;
  logic            deliver;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;
    // The synchroniser's reset value is not a line observation; arm only once
    // rx_s carries real samples, so a line held low through release stays idle.
    armed_d = armed_q | (rx_s & fill_q[1]);

    case (state_q)
      IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == MID_TICK) begin
            state_d = rx_s ? IDLE : DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            state_d = IDLE;
            tick_d  = '0;
            if (rx_s) deliver = 1'b1;
            else      ferr_d  = 1'b1;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as an accept keeps rx_valid high with no bubble.
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      armed_q <= armed_d;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected events, a
// monitor pops them when the DUT loads a byte or pulses an error flag.
module tb_uart_rx_ctrl;

  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int  total = 0;
  int  bad   = 0;
  int  tp    = 1;
  ev_t exp_q[$];

  uart_rx_ctrl #(.DBIT(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick: one clk wide, every tp-th clk
  initial begin
    int c;
    c = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (c >= tp) c = 0;
      s_tick = (c == 0);
      c = c + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [7:0] data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d data=%02h, want none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_BYTE && e.data != data)) begin
        bad++;
        $display("FAIL event: got kind=%0d data=%02h, want kind=%0d data=%02h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: a load is valid=1 after an edge where the register was empty or accepted.
  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid && (!pv || rx_ready)) pop_check(EV_BYTE, rx_data);
      if (pv && rx_valid && !rx_ready) chk("data_hold", 32'(rx_data), 32'(pd));
      if (frame_err) pop_check(EV_FERR, 8'h00);
      if (overrun)   pop_check(EV_OVR, 8'h00);
      pv = rx_valid;
      pd = rx_data;
    end
  end

  // One frame: start, 8 data bits LSB first, stop. ready_at pulses rx_ready at
  // that clk index; cut >= 0 abandons the frame at that clk index.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int ready_at, input int cut);
    int nb;
    int idx;
    nb = 16 * tp;
    for (int c = 0; c < 10 * nb; c++) begin
      @(negedge clk);
      if (cut >= 0 && c == cut) return;
      idx = c / nb;
      if (idx == 0)      rx = 1'b0;
      else if (idx <= 8) rx = b[idx-1];
      else               rx = stop_v;
      if (c == ready_at) rx_ready = 1'b1;
      else if (ready_at >= 0 && c == ready_at + 1) rx_ready = 1'b0;
    end
  endtask

  task automatic reset_case(input int tick_period, input string tag);
    tp = tick_period;
    rx_ready = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(8'h5A, 1'b1, -1, 4 * 16 * tp);
    rx = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_rst_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rst_busy"}, 32'(rx_busy), 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk({tag, "_low_after_release_busy"}, 32'(rx_busy), 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    push(EV_BYTE, 8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1);
    repeat (4 * tp) @(negedge clk);
    chk({tag, "_valid_drained"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_data", 32'(rx_data), 32'd0);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    chk("reset_ovr", 32'(overrun), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // 1: plain byte, consumer always ready
    rx_ready = 1'b1;
    push(EV_BYTE, 8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("t1_valid_one_clk", 32'(rx_valid), 32'd0);
    chk("t1_busy_idle", 32'(rx_busy), 32'd0);

    // 2: short low glitch rejected in START
    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_busy_in_start", 32'(rx_busy), 32'd1);
    @(negedge clk) rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t2_busy_back_idle", 32'(rx_busy), 32'd0);
    chk("t2_valid", 32'(rx_valid), 32'd0);

    // 3: framing error, then a good frame
    push(EV_FERR, 8'h00);
    send_frame(8'h3C, 1'b0, -1, -1);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("t3_valid_after_ferr", 32'(rx_valid), 32'd0);
    push(EV_BYTE, 8'h01);
    send_frame(8'h01, 1'b1, -1, -1);
    repeat (4) @(negedge clk);

    // 4: overrun while holding 0x11
    rx_ready = 1'b0;
    push(EV_BYTE, 8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    push(EV_OVR, 8'h00);
    send_frame(8'h22, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    chk("t4_data_kept", 32'(rx_data), 32'h11);
    chk("t4_valid_kept", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    chk("t4_valid_cleared", 32'(rx_valid), 32'd0);

    // 5: accept in the exact clk of completion (clk index 154 of the frame)
    push(EV_BYTE, 8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    push(EV_BYTE, 8'h22);
    send_frame(8'h22, 1'b1, 154, -1);
    repeat (4) @(negedge clk);
    chk("t5_data", 32'(rx_data), 32'h22);
    chk("t5_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t5_drained", 32'(rx_valid), 32'd0);

    // 6: reset mid-frame with line held low, at two tick rates
    reset_case(1, "t6a");
    reset_case(4, "t6b");

    tp = 1;
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
